// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial input, parallel word handshake and status of the deserializer.
interface sipo_deser_if #(
    parameter int WIDTH = 8,
    parameter int CW = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_bit;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    bit_cnt;
    logic             overflow;

    modport master (
        output in_valid, in_bit, out_ready,
        input  out_data, out_valid, bit_cnt, overflow
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output out_data, out_valid, bit_cnt, overflow
    );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with a one-entry holding register.
module sipo_deser #(
    parameter int WIDTH = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    sipo_deser_if.slave s
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] word;
    logic             done;

    // word is the shift register after taking in_bit, so it is also the completed word
    assign word = MSB_FIRST ? {sh[WIDTH-2:0], s.in_bit} : {s.in_bit, sh[WIDTH-1:1]};
    assign done = s.in_valid && (s.bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            sh          <= '0;
            s.bit_cnt   <= '0;
            s.out_data  <= '0;
            s.out_valid <= 1'b0;
            s.overflow  <= 1'b0;
        end else begin
            if (s.in_valid) begin
                sh        <= word;
                s.bit_cnt <= done ? '0 : s.bit_cnt + CW'(1);
            end
            if (done && (!s.out_valid || s.out_ready)) begin
                s.out_data  <= word;
                s.out_valid <= 1'b1;
            end else if (done) begin
                s.overflow <= 1'b1;
            end else if (s.out_valid && s.out_ready) begin
                s.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: drives MSB-first and LSB-first instances with one stream and checks both against a word-level model.
module tb_sipo_deser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sipo_deser_if #(.WIDTH(8)) im ();
    sipo_deser_if #(.WIDTH(8)) il ();

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .clr(clr), .s(im));
    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .clr(clr), .s(il));

    // reference: received bits are collected, the word is built by weighting bit positions
    bit       mbits[8];
    int       mcnt = 0;
    bit [7:0] mdm = '0;
    bit [7:0] mdl = '0;
    bit       mvalid = 1'b0;
    bit       movf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mcnt = 0; mdm = '0; mdl = '0; mvalid = 1'b0; movf = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit r, input bit c);
        bit       done = 1'b0;
        bit [7:0] wm = '0;
        bit [7:0] wl = '0;
        if (c) begin
            model_reset();
            return;
        end
        if (v) begin
            mbits[mcnt] = b;
            mcnt++;
            if (mcnt == 8) begin
                for (int i = 0; i < 8; i++) begin
                    wm = wm + (8'(mbits[i]) << (7 - i));
                    wl = wl + (8'(mbits[i]) << i);
                end
                done = 1'b1;
                mcnt = 0;
            end
        end
        if (done) begin
            if (!mvalid || r) begin
                mdm = wm; mdl = wl; mvalid = 1'b1;
            end else begin
                movf = 1'b1;
            end
        end else if (mvalid && r) begin
            mvalid = 1'b0;
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, "_valid_m"}, 32'(im.out_valid), 32'(mvalid));
        chk({tag, "_valid_l"}, 32'(il.out_valid), 32'(mvalid));
        chk({tag, "_cnt_m"}, 32'(im.bit_cnt), 32'(mcnt));
        chk({tag, "_cnt_l"}, 32'(il.bit_cnt), 32'(mcnt));
        chk({tag, "_ovf_m"}, 32'(im.overflow), 32'(movf));
        chk({tag, "_ovf_l"}, 32'(il.overflow), 32'(movf));
        chk({tag, "_data_m"}, 32'(im.out_data), 32'(mdm));
        chk({tag, "_data_l"}, 32'(il.out_data), 32'(mdl));
    endtask

    task automatic cyc(input bit v, input bit b, input bit r, input bit c);
        im.in_valid = v; im.in_bit = b; im.out_ready = r;
        il.in_valid = v; il.in_bit = b; il.out_ready = r;
        clr = c;
        @(posedge clk);
        model_step(v, b, r, c);
        #1;
        clr = 1'b0;
        compare("cyc");
    endtask

    // sends w MSB-first, with up to maxgap idle cycles before each bit; lrdy is out_ready on the last bit
    task automatic send(input logic [7:0] w, input int maxgap, input bit rdy, input bit lrdy);
        for (int i = 7; i >= 0; i--) begin
            repeat ($urandom_range(maxgap, 0)) cyc(1'b0, 1'($urandom), rdy, 1'b0);
            cyc(1'b1, w[i], (i == 0) ? lrdy : rdy, 1'b0);
        end
    endtask

    initial begin
        im.in_valid = 1'b0; im.in_bit = 1'b0; im.out_ready = 1'b0;
        il.in_valid = 1'b1; il.in_bit = 1'b1; il.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(im.out_valid), 0);
        chk("rst_cnt", 32'(il.bit_cnt), 0);
        chk("rst_data", 32'(il.out_data), 0);
        rst = 1'b0;
        compare("rst");

        send(8'hB4, 0, 1'b1, 1'b1);
        chk("t1_msb", 32'(im.out_data), 32'hB4);
        chk("t1_lsb", 32'(il.out_data), 32'h2D);
        chk("t1_valid", 32'(im.out_valid), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_pulse", 32'(im.out_valid), 0);

        send(8'hB4, 3, 1'b1, 1'b1);
        chk("t2_lsb", 32'(il.out_data), 32'h2D);

        send(8'h01, 0, 1'b1, 1'b1);
        chk("t3_w0", 32'(im.out_data), 32'h01);
        send(8'hFF, 0, 1'b1, 1'b1);
        chk("t3_w1", 32'(im.out_data), 32'hFF);
        send(8'h80, 0, 1'b1, 1'b1);
        chk("t3_w2", 32'(im.out_data), 32'h80);
        chk("t3_ovf", 32'(im.overflow), 0);

        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        send(8'h3C, 1, 1'b0, 1'b0);
        send(8'hC3, 1, 1'b0, 1'b0);
        chk("t4_hold", 32'(im.out_data), 32'h3C);
        chk("t4_ovf", 32'(im.overflow), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_drain", 32'(im.out_valid), 0);
        chk("t4_sticky", 32'(im.overflow), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_clr", 32'(im.overflow), 0);

        send(8'h11, 0, 1'b0, 1'b0);
        send(8'h22, 2, 1'b0, 1'b1);
        chk("t5_data", 32'(im.out_data), 32'h22);
        chk("t5_valid", 32'(im.out_valid), 1);
        chk("t5_ovf", 32'(im.overflow), 0);

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t6_clr_cnt", 32'(im.bit_cnt), 0);
        chk("t6_clr_valid", 32'(im.out_valid), 0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_cnt", 32'(im.bit_cnt), 0);
        chk("t6_rst_valid", 32'(im.out_valid), 0);
        model_reset();
        rst = 1'b0;
        send(8'hA7, 0, 1'b0, 1'b0);
        chk("t6_msb", 32'(im.out_data), 32'hA7);
        chk("t6_lsb", 32'(il.out_data), 32'hE5);

        for (int i = 0; i < 4000; i++)
            cyc(1'($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom_range(2, 0) != 0),
                $urandom_range(199, 0) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
